cic_sample_fifo: RTL and testbench
==================================

CIC_SAMPLE_FIFO -- requirements
Module: cic_sample_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock and rst is asynchronous, asserted at 0.
REQ-002 The parameter DEPTH_LOG2 SHALL default to 4 and set FIFO depth DEPTH = 2^DEPTH_LOG2; legal range is 2..8.
REQ-003 clk  input  1  system clock (50 MHz).
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_data  input  32  CIC output word, with the sample in bits [23:0] and the tag byte in bits [31:24].
REQ-006 in_valid  input  1  single-cycle strobe qualifying in_data.
REQ-007 out_data  output  32  head-of-FIFO word {tag[7:0], sample[23:0]}.
REQ-008 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-009 out_ready  input  1  consumer accept; a pop occurs when out_valid && out_ready.
REQ-010 count  output  DEPTH_LOG2+1  current fill level, 0..DEPTH.
REQ-011 half_full  output  1  high when count >= DEPTH/2.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 clr_ovf  input  1  single-cycle clear for ovf.

Function
REQ-014 The FIFO SHALL be first-word-fall-through: whenever out_valid=1, out_data equals the oldest stored entry.
REQ-015 A push SHALL occur on in_valid=1 when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-016 Write-to-out_valid latency SHALL be 1 cycle: a push into an empty FIFO raises out_valid on the next clock edge, with no combinational bypass.
REQ-017 On simultaneous push and pop, count SHALL be unchanged and both operations SHALL complete.
REQ-018 On in_valid=1 with count=DEPTH and no pop, the sample SHALL be dropped, FIFO contents and count SHALL be unchanged, and ovf SHALL set on the next edge.
REQ-019 ovf SHALL hold until clr_ovf=1; if a set and clr_ovf coincide, the set wins.
REQ-020 A pop on an empty FIFO SHALL be impossible: out_ready with out_valid=0 is ignored.
REQ-021 Read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap from DEPTH-1 to 0.
REQ-022 count, out_valid and half_full SHALL be registered outputs updated on the same edge as the pointers.
REQ-023 in_data[23:0] SHALL be stored unmodified; no sign extension or scaling is applied.
REQ-024 The stored tag byte SHALL be selected per the Configuration section.

Reset
REQ-025 Asserting rst SHALL immediately and asynchronously clear both pointers, count, out_valid, half_full, ovf, and the sequence counter.
REQ-026 out_data SHALL read 32'd0 during and after reset until the first push.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored samples; an in_valid in the same cycle as the reset release edge SHALL be ignored.
REQ-029 Deassertion of rst SHALL be synchronized internally with a two-flop release to clk.

Configuration
REQ-030 Macro CIC_FIFO_SEQ_EN SHALL select the source of the stored tag byte.
REQ-031 With CIC_FIFO_SEQ_EN defined, tag SHALL be an 8-bit sequence counter value sampled at the in_valid; the counter increments on every in_valid, whether pushed or dropped, and wraps 255->0, so drops appear as tag gaps.
REQ-032 Without CIC_FIFO_SEQ_EN, tag SHALL be in_data[31:24] passed through, and no sequence counter SHALL be instantiated.

Verification
REQ-033 Reset, then push 3 words 0x08000001..0x08000003 with out_ready=0 -> count=3; out_valid rises 1 cycle after the first push; out_data=0x08000001.
REQ-034 DEPTH=16 (DEPTH_LOG2=4): push 17 words with out_ready=0 -> count=16, ovf=1, half_full=1 from the 8th push; draining returns words 1..16 in order and word 17 is absent.
REQ-035 With count=16, pulse in_valid and out_ready in the same cycle -> count stays 16, ovf stays 0, and the new word becomes the tail.
REQ-036 Pulse clr_ovf coincident with a dropping in_valid -> ovf remains 1; a lone clr_ovf pulse on the next cycle -> ovf=0.
REQ-037 With CIC_FIFO_SEQ_EN: push 300 strobes while draining continuously -> tags run 0..255 then 0..43 with no gaps; force one overflow -> exactly one tag missing.
REQ-038 Assert rst mid-stream with count=5 -> count=0, out_valid=0, out_data=0 without waiting for a clock; the first push after release reads back correctly.

Source files
------------

// File: rtl/cic_sample_fifo_if.sv
// rtl/cic_sample_fifo_if.sv - handshake and status bundle for the CIC sample FIFO
//
// Producer side : in_data[31:0] {tag, sample[23:0]}, in_valid strobe
// Consumer side : out_data[31:0] head word, out_valid, out_ready
// Status/control: count[DEPTH_LOG2:0], half_full, ovf (sticky), clr_ovf
// master = the block feeding/draining the FIFO, slave = the FIFO itself.
interface cic_sample_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [31:0]         in_data;
    logic                in_valid;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_ready;
    logic [DEPTH_LOG2:0] count;
    logic                half_full;
    logic                ovf;
    logic                clr_ovf;

    modport master (
        output in_data, in_valid, out_ready, clr_ovf,
        input  out_data, out_valid, count, half_full, ovf
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_ovf,
        output out_data, out_valid, count, half_full, ovf
    );
endinterface

// File: rtl/cic_sample_fifo.sv
// rtl/cic_sample_fifo.sv - first-word-fall-through FIFO for tagged CIC output samples
//
// Ports:
//   clk  - single clock
//   rst  - asynchronous active-low reset; release is synchronized to clk by two flops
//   bus  - cic_sample_fifo_if.slave (in_data/in_valid, out_data/out_valid/out_ready,
//          count, half_full, ovf, clr_ovf)
// Parameter DEPTH_LOG2 (2..8): depth = 2**DEPTH_LOG2.
// Macro CIC_FIFO_SEQ_EN: when defined the stored tag byte is an internal 8-bit
// sequence number; otherwise in_data[31:24] is stored as the tag.
module cic_sample_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    cic_sample_fifo_if.slave bus
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] HALF_LVL = (DEPTH_LOG2 + 1)'(DEPTH / 2);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    // Reset release synchronizer: assertion clears it at once, release ripples
    // through two flops so the FIFO only starts acting two edges after rst rises.
    // The edge on which rst is released therefore never sees a push.
    logic [1:0] rel_q;
    logic       run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_q <= 2'b00;
        end else begin
            rel_q <= {rel_q[0], 1'b1};
        end
    end

    assign run = rel_q[1];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  half_full_q, half_full_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, drop;
    logic [7:0]            tag;

    // Storage is deliberately not reset; out_data is masked while empty instead.
    logic [31:0] mem [DEPTH];

    always_comb begin
        pop  = run && out_valid_q && bus.out_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push = run && bus.in_valid && ((count_q != FULL_LVL) || pop);
        drop = run && bus.in_valid && !push;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // Pointers are exactly DEPTH_LOG2 bits so they wrap DEPTH-1 -> 0 naturally.
        wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        out_valid_d = (count_d != '0);
        half_full_d = (count_d >= HALF_LVL);

        // A drop in the same cycle as a clear wins so no overflow is ever lost.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (run && bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            half_full_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            half_full_q <= half_full_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef CIC_FIFO_SEQ_EN
    // Sequence number advances on every strobe, stored or dropped, so a
    // dropped sample shows up downstream as a gap in the tags.
    logic [7:0] seq_q, seq_d;
    logic [7:0] unused_in_tag;

    assign seq_d         = (run && bus.in_valid) ? (seq_q + 8'd1) : seq_q;
    assign tag           = seq_q;
    assign unused_in_tag = bus.in_data[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    assign tag = bus.in_data[31:24];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {tag, bus.in_data[23:0]};
        end
    end

    assign bus.out_data  = out_valid_q ? mem[rd_ptr_q] : 32'd0;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.half_full = half_full_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cic_sample_fifo.sv
// tb/tb_cic_sample_fifo.sv - self-checking bench for cic_sample_fifo
module tb_cic_sample_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    cic_sample_fifo_if #(.DEPTH_LOG2(DL2)) bus ();
    cic_sample_fifo #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a queue of stored words plus the sticky flag and tag counter.
    logic [31:0] exp_q [$];
    logic        exp_ovf = 1'b0;
    logic [7:0]  exp_seq = 8'd0;

    function automatic logic [31:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 32'd0;
    endfunction

    // Drive one clock worth of inputs, advance the model by the FIFO rules,
    // then step past the edge. Returns 1 ns after the edge.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic rdy, input logic clr);
        logic        pop, push;
        logic [31:0] word;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        pop  = rdy && (exp_q.size() != 0);
        push = iv && ((exp_q.size() < DEPTH) || pop);
`ifdef CIC_FIFO_SEQ_EN
        word = {exp_seq, d[23:0]};
        if (iv) exp_seq = exp_seq + 8'd1;
`else
        word = d;
`endif
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(word);
        if (iv && !push) exp_ovf = 1'b1;
        else if (clr)    exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic do_reset(input logic iv_at_release);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = iv_at_release;
        bus.in_data  = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_seq = 8'd0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        tests_run++;
        if (bus.count !== 5'd0) begin
            tests_failed++; $display("FAIL rst_count: got %0d expected 0", bus.count);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== 32'd0) begin
            tests_failed++; $display("FAIL rst_out_data: got %h expected 00000000", bus.out_data);
        end
        tests_run++;
        if (bus.half_full !== 1'b0) begin
            tests_failed++; $display("FAIL rst_half_full: got %b expected 0", bus.half_full);
        end
        tests_run++;
        if (bus.ovf !== 1'b0) begin
            tests_failed++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf);
        end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        // Strobe presented but edge not yet taken: no bypass to out_valid.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0800_0001;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_no_bypass: got %b expected 0", bus.out_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 32'h0800_0000 + 32'(i), 1'b0, 1'b0);
            if (i == 1) begin
                tests_run++;
                if (bus.out_valid !== 1'b1) begin
                    tests_failed++; $display("FAIL basic_latency: got %b expected 1", bus.out_valid);
                end
            end
        end
        tests_run++;
        if (bus.count !== 5'd3) begin
            tests_failed++; $display("FAIL basic_count: got %0d expected 3", bus.count);
        end
        tests_run++;
        if (bus.out_data !== exp_head()) begin
            tests_failed++; $display("FAIL basic_head: got %h expected %h", bus.out_data, exp_head());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] tail;
        do_reset(1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0);
            tests_run++;
            if (bus.half_full !== (i >= DEPTH / 2)) begin
                tests_failed++; $display("FAIL ovf_half_full push %0d: got %b expected %b", i, bus.half_full, (i >= DEPTH / 2));
            end
        end
        tests_run++;
        if (bus.count !== 5'(DEPTH)) begin
            tests_failed++; $display("FAIL ovf_full_count: got %0d expected %0d", bus.count, DEPTH);
        end
        // Full FIFO, push and pop together.
        tail = $urandom;
        cycle(1'b1, tail, 1'b1, 1'b0);
        tail = exp_q[exp_q.size() - 1];
        tests_run++;
        if (bus.count !== 5'(DEPTH)) begin
            tests_failed++; $display("FAIL simul_count: got %0d expected %0d", bus.count, DEPTH);
        end
        tests_run++;
        if (bus.ovf !== 1'b0) begin
            tests_failed++; $display("FAIL simul_ovf: got %b expected 0", bus.ovf);
        end
        // Dropping strobe.
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        tests_run++;
        if (bus.ovf !== 1'b1 || bus.count !== 5'(DEPTH)) begin
            tests_failed++; $display("FAIL drop_ovf: got ovf=%b count=%0d expected ovf=1 count=%0d", bus.ovf, bus.count, DEPTH);
        end
        // Clear coinciding with a drop: set wins.
        cycle(1'b1, $urandom, 1'b0, 1'b1);
        tests_run++;
        if (bus.ovf !== 1'b1) begin
            tests_failed++; $display("FAIL clr_vs_set: got %b expected 1", bus.ovf);
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        tests_run++;
        if (bus.ovf !== 1'b0) begin
            tests_failed++; $display("FAIL clr_alone: got %b expected 0", bus.ovf);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_head()) begin
                tests_failed++; $display("FAIL drain word %0d: got %h (valid %b) expected %h", i, bus.out_data, bus.out_valid, exp_head());
            end
            if (i == DEPTH - 1) begin
                tests_run++;
                if (bus.out_data !== tail) begin
                    tests_failed++; $display("FAIL drain_tail: got %h expected %h", bus.out_data, tail);
                end
            end
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        tests_run++;
        if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL drain_empty: got count=%0d valid=%b expected 0/0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_random();
        int  errs;
        logic iv, rdy, clr;
        do_reset(1'b0);
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            // First half leans toward filling, second half toward draining.
            iv  = ($urandom_range(0, 99) < ((i < 300) ? 75 : 30));
            rdy = ($urandom_range(0, 99) < ((i < 300) ? 30 : 75));
            clr = ($urandom_range(0, 99) < 5);
            // Ready asserted on an empty FIFO must be ignored.
            cycle(iv, $urandom, rdy, clr);
            tests_run++;
            if (bus.count !== 5'(exp_q.size()) || bus.out_valid !== (exp_q.size() != 0) ||
                bus.half_full !== (exp_q.size() >= DEPTH / 2) || bus.ovf !== exp_ovf ||
                (exp_q.size() != 0 && bus.out_data !== exp_head())) begin
                tests_failed++;
                $display("FAIL rnd cycle %0d: got cnt=%0d v=%b hf=%b ovf=%b d=%h expected cnt=%0d ovf=%b d=%h",
                         i, bus.count, bus.out_valid, bus.half_full, bus.ovf, bus.out_data,
                         exp_q.size(), exp_ovf, exp_head());
            end
        end
    endtask

`ifdef CIC_FIFO_SEQ_EN
    task automatic test_seq();
        int         n, gaps;
        logic [7:0] t, prev, first;
        do_reset(1'b1);
        n = 0;
        for (int i = 0; i < 300 + 4; i++) begin
            if (bus.out_valid) begin
                tests_run++;
                if (bus.out_data[31:24] !== 8'(n)) begin
                    tests_failed++; $display("FAIL seq_tag %0d: got %0d expected %0d", n, bus.out_data[31:24], 8'(n));
                end
                n++;
            end
            cycle(i < 300, $urandom, 1'b1, 1'b0);
        end
        tests_run++;
        if (n !== 300) begin
            tests_failed++; $display("FAIL seq_total: got %0d expected 300", n);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        n = 0; gaps = 0; prev = 8'd0; first = 8'd0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (bus.out_valid) begin
                t = bus.out_data[31:24];
                if (n == 0) first = t;
                else if (t != 8'(prev + 8'd1)) gaps++;
                prev = t;
                n++;
            end
            cycle(i == 0, $urandom, 1'b1, 1'b0);
        end
        tests_run++;
        if (gaps !== 1 || 8'(prev - first) !== 8'(n)) begin
            tests_failed++; $display("FAIL seq_gap: got gaps=%0d span=%0d expected gaps=1 span=%0d", gaps, 8'(prev - first), n);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd5) begin
            tests_failed++; $display("FAIL mid_pre_count: got %0d expected 5", bus.count);
        end
        #4;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) begin
            tests_failed++; $display("FAIL mid_async_clear: got cnt=%0d v=%b d=%h expected 0/0/0", bus.count, bus.out_valid, bus.out_data);
        end
        do_reset(1'b0);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 5'd1 || bus.out_data !== exp_head()) begin
            tests_failed++; $display("FAIL mid_first_push: got cnt=%0d d=%h expected 1 %h", bus.count, bus.out_data, exp_head());
        end
    endtask

    initial begin
        bus.in_data   = 32'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_random();
`ifdef CIC_FIFO_SEQ_EN
        test_seq();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
